// File: rtl/noc_pkg.sv
// Shared definitions for the 2D-mesh XY wormhole router.
//   - port_e      : router port index (Local, North, East, South, West)
//   - flit_type_e : encoding of the 2-bit flit type field
//   - in_state_e / out_state_e : per-input and per-output wormhole state
//   - field offset helpers for the type and destination coordinate fields
package noc_pkg;

  localparam int NUM_PORTS = 5;

  typedef enum logic [2:0] {
    PORT_L = 3'd0,
    PORT_N = 3'd1,
    PORT_E = 3'd2,
    PORT_S = 3'd3,
    PORT_W = 3'd4
  } port_e;

  typedef enum logic [1:0] {
    FLIT_BODY   = 2'b00,
    FLIT_TAIL   = 2'b01,
    FLIT_HEAD   = 2'b10,
    FLIT_SINGLE = 2'b11
  } flit_type_e;

  typedef enum logic {
    IN_IDLE = 1'b0,
    IN_PKT  = 1'b1
  } in_state_e;

  typedef enum logic {
    OUT_FREE   = 1'b0,
    OUT_LOCKED = 1'b1
  } out_state_e;

  // Type field occupies the two MSBs.
  function automatic int type_lsb(input int flit_w);
    return flit_w - 2;
  endfunction

  // Destination X sits directly below the type field.
  function automatic int dest_x_lsb(input int flit_w, input int coord_w);
    return flit_w - 2 - coord_w;
  endfunction

  // Destination Y sits directly below destination X.
  function automatic int dest_y_lsb(input int flit_w, input int coord_w);
    return flit_w - 2 - 2 * coord_w;
  endfunction

  // Round-robin successor, wrapping West back to Local.
  function automatic port_e next_port(input port_e p);
    return (p == PORT_W) ? PORT_L : port_e'(p + 3'd1);
  endfunction

endpackage

// File: rtl/noc_xy_router_if.sv
// Bundle of the five input and five output links of one router.
//   flit_in/valid_in/ready_out  : upstream side, one lane per port
//   flit_out/valid_out/ready_in : downstream side, one lane per port
// Modport master drives the router (neighbours / bench), modport slave is
// the router itself.
interface noc_xy_router_if
  import noc_pkg::*;
#(
  parameter int FLIT_W = 64
);

  logic [FLIT_W-1:0]    flit_in   [NUM_PORTS];
  logic [NUM_PORTS-1:0] valid_in;
  logic [NUM_PORTS-1:0] ready_out;
  logic [FLIT_W-1:0]    flit_out  [NUM_PORTS];
  logic [NUM_PORTS-1:0] valid_out;
  logic [NUM_PORTS-1:0] ready_in;

  modport master (
    output flit_in, valid_in, ready_in,
    input  ready_out, flit_out, valid_out
  );

  modport slave (
    input  flit_in, valid_in, ready_in,
    output ready_out, flit_out, valid_out
  );

endinterface

// File: rtl/noc_fifo.sv
// Per-input flit buffer: circular storage with registered pointers/count.
//   push_i/din_i : write (ignored when full)
//   pop_i        : read advance (ignored when empty)
//   dout_o       : current head entry, valid while !empty_o
//   full_o/empty_o/count_o : occupancy derived from the registered count
module noc_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [W-1:0]               din_i,
  input  logic                       pop_i,
  output logic [W-1:0]               dout_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // NOTE: the storage array is deliberately not reset; only pointers and
  // count are, and empty_o guards every read, so stale data is never used.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // Power-of-two depth lets the pointers wrap naturally.
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/noc_xy_router.sv
// 5-port wormhole router with dimension-order (X then Y) routing.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : five input lanes (flit/valid/ready_out) and five output
//                lanes (flit/valid/ready_in), port 0=L 1=N 2=E 3=S 4=W
//   drop_pulse : high for the cycle in which any malformed flit
//                (BODY/TAIL at the head of an idle input) is discarded
// Each input owns a FIFO and an IDLE/IN_PKT state with a latched route.
// Each output owns a FREE/LOCKED state, an owner and a round-robin pointer.
module noc_xy_router
  import noc_pkg::*;
#(
  parameter int FLIT_W     = 64,
  parameter int FIFO_DEPTH = 4,
  parameter int COORD_W    = 3,
  parameter int MY_X       = 0,
  parameter int MY_Y       = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  noc_xy_router_if.slave   bus,
  output logic             drop_pulse
);

  localparam int TYPE_LSB = type_lsb(FLIT_W);
  localparam int X_LSB    = dest_x_lsb(FLIT_W, COORD_W);
  localparam int Y_LSB    = dest_y_lsb(FLIT_W, COORD_W);
  localparam int CNT_W    = $clog2(FIFO_DEPTH) + 1;

  localparam logic [COORD_W-1:0] MY_X_C = COORD_W'(MY_X);
  localparam logic [COORD_W-1:0] MY_Y_C = COORD_W'(MY_Y);

  // Input side
  logic [FLIT_W-1:0]    head_flit [NUM_PORTS];
  flit_type_e           head_type [NUM_PORTS];
  port_e                head_route[NUM_PORTS];
  logic [NUM_PORTS-1:0] fifo_full, fifo_empty, fifo_push, fifo_pop;
  // Occupancy is available for debug; routing only needs full/empty.
  logic [CNT_W-1:0]     fifo_count_unused [NUM_PORTS];
  logic [NUM_PORTS-1:0] drop;

  in_state_e in_state_q [NUM_PORTS], in_state_d [NUM_PORTS];
  port_e     route_q    [NUM_PORTS], route_d    [NUM_PORTS];

  // Output side
  out_state_e out_state_q [NUM_PORTS], out_state_d [NUM_PORTS];
  port_e      owner_q     [NUM_PORTS], owner_d     [NUM_PORTS];
  port_e      rr_ptr_q    [NUM_PORTS], rr_ptr_d    [NUM_PORTS];
  port_e      out_sel     [NUM_PORTS];
  logic [FLIT_W-1:0]    out_flit [NUM_PORTS];
  logic [NUM_PORTS-1:0] grant_valid, out_valid, out_pop;

  // Holds ready_out low during reset and for the first edge after release.
  logic ready_en_q;

  function automatic port_e xy_route(input logic [FLIT_W-1:0] f);
    logic [COORD_W-1:0] dx, dy;
    dx = f[X_LSB +: COORD_W];
    dy = f[Y_LSB +: COORD_W];
    if (dx > MY_X_C)      return PORT_E;
    else if (dx < MY_X_C) return PORT_W;
    else if (dy > MY_Y_C) return PORT_N;
    else if (dy < MY_Y_C) return PORT_S;
    else                  return PORT_L;
  endfunction

  assign bus.ready_out = {NUM_PORTS{ready_en_q}} & ~fifo_full;
  assign fifo_push     = bus.valid_in & bus.ready_out;
  assign bus.valid_out = out_valid;
  assign drop_pulse    = |drop;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    noc_fifo #(
      .W     (FLIT_W),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (fifo_push[i]),
      .din_i   (bus.flit_in[i]),
      .pop_i   (fifo_pop[i]),
      .dout_o  (head_flit[i]),
      .full_o  (fifo_full[i]),
      .empty_o (fifo_empty[i]),
      .count_o (fifo_count_unused[i])
    );

    assign head_type[i]    = flit_type_e'(head_flit[i][TYPE_LSB +: 2]);
    assign head_route[i]   = xy_route(head_flit[i]);
    assign bus.flit_out[i] = out_flit[i];
  end

  // NOTE: every signal written here gets a default first, so no path
  // through the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    int    sum;
    port_e idx;
    sum         = 0;
    idx         = PORT_L;
    drop        = '0;
    fifo_pop    = '0;
    grant_valid = '0;
    out_valid   = '0;
    out_pop     = '0;
    in_state_d  = in_state_q;
    route_d     = route_q;
    out_state_d = out_state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    for (int o = 0; o < NUM_PORTS; o++) begin
      out_sel[o]  = PORT_L;
      out_flit[o] = '0;
    end

    // Malformed flits: a packet continuation with no packet open.
    for (int i = 0; i < NUM_PORTS; i++) begin
      drop[i] = !fifo_empty[i] && (in_state_q[i] == IN_IDLE) &&
                (head_type[i] == FLIT_BODY || head_type[i] == FLIT_TAIL);
    end

    for (int o = 0; o < NUM_PORTS; o++) begin
      if (out_state_q[o] == OUT_LOCKED) begin
        // Whatever the owner presents belongs to the open packet.
        out_sel[o]   = owner_q[o];
        out_valid[o] = !fifo_empty[owner_q[o]];
      end else begin
        // First idle input with a head flit for this output, from rr_ptr.
        for (int k = 0; k < NUM_PORTS; k++) begin
          sum = int'(rr_ptr_q[o]) + k;
          if (sum >= NUM_PORTS) sum = sum - NUM_PORTS;
          idx = port_e'(sum);
          if (!grant_valid[o] && !fifo_empty[idx] &&
              (in_state_q[idx] == IN_IDLE) &&
              (head_type[idx] == FLIT_HEAD || head_type[idx] == FLIT_SINGLE) &&
              (head_route[idx] == port_e'(o))) begin
            grant_valid[o] = 1'b1;
            out_sel[o]     = idx;
          end
        end
        out_valid[o] = grant_valid[o];
      end

      out_pop[o] = out_valid[o] & bus.ready_in[o];
      if (out_valid[o]) out_flit[o] = head_flit[out_sel[o]];

      if (out_pop[o]) begin
        fifo_pop[out_sel[o]] = 1'b1;
        if (out_state_q[o] == OUT_FREE) begin
          rr_ptr_d[o] = next_port(out_sel[o]);
          if (head_type[out_sel[o]] == FLIT_HEAD) begin
            out_state_d[o]         = OUT_LOCKED;
            owner_d[o]             = out_sel[o];
            in_state_d[out_sel[o]] = IN_PKT;
            route_d[out_sel[o]]    = port_e'(o);
          end
        end else if (head_type[out_sel[o]] == FLIT_TAIL) begin
          out_state_d[o]         = OUT_FREE;
          in_state_d[out_sel[o]] = IN_IDLE;
        end
      end
    end

    fifo_pop = fifo_pop | drop;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en_q <= 1'b0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        in_state_q[i]  <= IN_IDLE;
        route_q[i]     <= PORT_L;
        out_state_q[i] <= OUT_FREE;
        owner_q[i]     <= PORT_L;
        rr_ptr_q[i]    <= PORT_L;
      end
    end else begin
      ready_en_q  <= 1'b1;
      in_state_q  <= in_state_d;
      route_q     <= route_d;
      out_state_q <= out_state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

endmodule
